// File: rtl/debug_host_fsm.sv
// Host-side UART debug initiator: sends LOAD/RUN/STEP commands and program words,
// then reassembles the returned dump bytes into words. Optional RX watchdog: DEBUG_HOST_TIMEOUT_EN.
module debug_host_fsm #(
   parameter int unsigned UART_BITS        = 8,
   parameter int unsigned INSTRUCTION_BITS = 32,
   parameter int unsigned PC_BITS          = 8,
   parameter int unsigned DUMP_WORDS       = 48,
   parameter int unsigned DUMP_ADDR_BITS   = 6,
   parameter int unsigned TIMEOUT_CYCLES   = 1000000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_cmd_load,
   input  logic                        i_cmd_run,
   input  logic                        i_cmd_step,
   input  logic [PC_BITS-1:0]          i_inst_count,
   output logic [PC_BITS-1:0]          o_rom_addr,
   input  logic [INSTRUCTION_BITS-1:0] i_rom_data,
   output logic                        o_tx_start,
   output logic [UART_BITS-1:0]        o_tx_data,
   input  logic                        i_tx_done,
   input  logic                        i_rx_done,
   input  logic [UART_BITS-1:0]        i_rx_data,
   output logic                        o_dump_we,
   output logic [DUMP_ADDR_BITS-1:0]   o_dump_addr,
   output logic [INSTRUCTION_BITS-1:0] o_dump_data,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_error
);

   localparam int unsigned SHIFT_BITS = INSTRUCTION_BITS - UART_BITS;
   localparam logic [UART_BITS-1:0] CMD_LOAD = UART_BITS'(1);
   localparam logic [UART_BITS-1:0] CMD_RUN  = UART_BITS'(2);
   localparam logic [UART_BITS-1:0] CMD_STEP = UART_BITS'(3);
   localparam logic [DUMP_ADDR_BITS-1:0] LAST_WORD = DUMP_ADDR_BITS'(DUMP_WORDS - 1);

   if (INSTRUCTION_BITS != 4 * UART_BITS || (1 << DUMP_ADDR_BITS) < DUMP_WORDS
       || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
      $error("debug_host_fsm: inconsistent parameters");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_WAIT_LO, S_WAIT_HI, S_FETCH, S_RECV, S_DONE
   } state_t;

   // Which part of a LOAD stream the byte just sent belonged to
   typedef enum logic [1:0] {H_CMD, H_CNT, H_WORD} hdr_t;

   state_t                        state_q, state_d;
   hdr_t                          hdr_q, hdr_d;
   logic                          is_load_q, is_load_d;
   logic [PC_BITS-1:0]            cnt_q, cnt_d;
   logic [PC_BITS-1:0]            wcnt_q, wcnt_d;
   logic [1:0]                    bcnt_q, bcnt_d;
   logic [INSTRUCTION_BITS-1:0]   word_q, word_d;
   logic [SHIFT_BITS-1:0]         shift_q, shift_d;
   logic [DUMP_ADDR_BITS-1:0]     widx_q, widx_d;
   logic [PC_BITS-1:0]            rom_addr_q, rom_addr_d;
   logic                          tx_start_q, tx_start_d;
   logic [UART_BITS-1:0]          tx_data_q, tx_data_d;
   logic                          dump_we_q, dump_we_d;
   logic [DUMP_ADDR_BITS-1:0]     dump_addr_q, dump_addr_d;
   logic [INSTRUCTION_BITS-1:0]   dump_data_q, dump_data_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;

`ifdef DEBUG_HOST_TIMEOUT_EN
   localparam int unsigned TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_BITS-1:0] tmo_q, tmo_d;
   logic                error_q, error_d;
   assign o_error = error_q;
`else
   assign o_error = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         hdr_q       <= H_CMD;
         is_load_q   <= 1'b0;
         cnt_q       <= '0;
         wcnt_q      <= '0;
         bcnt_q      <= '0;
         word_q      <= '0;
         shift_q     <= '0;
         widx_q      <= '0;
         rom_addr_q  <= '0;
         tx_start_q  <= 1'b0;
         tx_data_q   <= '0;
         dump_we_q   <= 1'b0;
         dump_addr_q <= '0;
         dump_data_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_q       <= hdr_d;
         is_load_q   <= is_load_d;
         cnt_q       <= cnt_d;
         wcnt_q      <= wcnt_d;
         bcnt_q      <= bcnt_d;
         word_q      <= word_d;
         shift_q     <= shift_d;
         widx_q      <= widx_d;
         rom_addr_q  <= rom_addr_d;
         tx_start_q  <= tx_start_d;
         tx_data_q   <= tx_data_d;
         dump_we_q   <= dump_we_d;
         dump_addr_q <= dump_addr_d;
         dump_data_q <= dump_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

`ifdef DEBUG_HOST_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q   <= '0;
         error_q <= 1'b0;
      end else begin
         tmo_q   <= tmo_d;
         error_q <= error_d;
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      hdr_d       = hdr_q;
      is_load_d   = is_load_q;
      cnt_d       = cnt_q;
      wcnt_d      = wcnt_q;
      bcnt_d      = bcnt_q;
      word_d      = word_q;
      shift_d     = shift_q;
      widx_d      = widx_q;
      rom_addr_d  = rom_addr_q;
      tx_data_d   = tx_data_q;
      dump_we_d   = 1'b0;
      dump_addr_d = dump_addr_q;
      dump_data_d = dump_data_q;
      done_d      = 1'b0;
`ifdef DEBUG_HOST_TIMEOUT_EN
      tmo_d       = tmo_q;
      error_d     = error_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (i_cmd_load || i_cmd_run || i_cmd_step) begin
               state_d    = S_SEND;
               hdr_d      = H_CMD;
               is_load_d  = i_cmd_load;
               wcnt_d     = '0;
               bcnt_d     = '0;
               shift_d    = '0;
               widx_d     = '0;
               rom_addr_d = '0;
               if (i_cmd_load) begin
                  cnt_d     = i_inst_count;
                  tx_data_d = CMD_LOAD;
               end else begin
                  tx_data_d = i_cmd_run ? CMD_RUN : CMD_STEP;
               end
`ifdef DEBUG_HOST_TIMEOUT_EN
               error_d = 1'b0;
`endif
            end
         end
         S_SEND:    state_d = S_WAIT_LO;
         S_WAIT_LO: if (!i_tx_done) state_d = S_WAIT_HI;
         S_WAIT_HI: begin
            if (i_tx_done) begin
               if (!is_load_q) begin
                  state_d = S_RECV;
`ifdef DEBUG_HOST_TIMEOUT_EN
                  tmo_d = '0;
`endif
               end else begin
                  case (hdr_q)
                     H_CMD: begin
                        hdr_d     = H_CNT;
                        tx_data_d = UART_BITS'(cnt_q);
                        state_d   = S_SEND;
                     end
                     H_CNT:   state_d = (cnt_q == '0) ? S_DONE : S_FETCH;
                     default: begin
                        if (bcnt_q == 2'd3) begin
                           state_d = (wcnt_q == cnt_q) ? S_DONE : S_FETCH;
                        end else begin
                           bcnt_d    = bcnt_q + 2'd1;
                           word_d    = {word_q[SHIFT_BITS-1:0], {UART_BITS{1'b0}}};
                           tx_data_d = word_q[SHIFT_BITS-1 -: UART_BITS];
                           state_d   = S_SEND;
                        end
                     end
                  endcase
               end
            end
         end
         // ROM address for this word has been stable since the previous word, so data is valid now
         S_FETCH: begin
            word_d    = i_rom_data;
            tx_data_d = i_rom_data[INSTRUCTION_BITS-1 -: UART_BITS];
            bcnt_d    = '0;
            hdr_d     = H_WORD;
            wcnt_d    = wcnt_q + PC_BITS'(1);
            if ((wcnt_q + PC_BITS'(1)) < cnt_q) rom_addr_d = rom_addr_q + PC_BITS'(1);
            state_d   = S_SEND;
         end
         S_RECV: begin
            if (i_rx_done) begin
               shift_d = {shift_q[SHIFT_BITS-UART_BITS-1:0], i_rx_data};
               bcnt_d  = bcnt_q + 2'd1;
`ifdef DEBUG_HOST_TIMEOUT_EN
               tmo_d   = '0;
`endif
               if (bcnt_q == 2'd3) begin
                  dump_we_d   = 1'b1;
                  dump_data_d = {shift_q, i_rx_data};
                  dump_addr_d = widx_q;
                  widx_d      = widx_q + DUMP_ADDR_BITS'(1);
                  if (widx_q == LAST_WORD) state_d = S_DONE;
               end
            end
`ifdef DEBUG_HOST_TIMEOUT_EN
            else if (tmo_q == TMO_BITS'(TIMEOUT_CYCLES - 1)) begin
               error_d = 1'b1;
               bcnt_d  = '0;
               shift_d = '0;
               state_d = S_DONE;
            end else begin
               tmo_d = tmo_q + TMO_BITS'(1);
            end
`endif
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      tx_start_d = (state_d == S_SEND);
      busy_d     = (state_d != S_IDLE);
   end

   assign o_rom_addr  = rom_addr_q;
   assign o_tx_start  = tx_start_q;
   assign o_tx_data   = tx_data_q;
   assign o_dump_we   = dump_we_q;
   assign o_dump_addr = dump_addr_q;
   assign o_dump_data = dump_data_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;

endmodule

// File: tb/tb_debug_host_fsm.sv
// Directed bench for debug_host_fsm: UART tx model with a 5-cycle busy window, registered ROM model,
// and negedge monitors logging transmitted bytes, dump writes and done pulses.
module tb_debug_host_fsm;

   localparam int unsigned UB = 8, IB = 32, PCB = 8, DW = 48, DAB = 6;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            i_cmd_load = 1'b0, i_cmd_run = 1'b0, i_cmd_step = 1'b0;
   logic [PCB-1:0]  i_inst_count = '0;
   logic [PCB-1:0]  o_rom_addr;
   logic [IB-1:0]   i_rom_data;
   logic            o_tx_start;
   logic [UB-1:0]   o_tx_data;
   logic            i_tx_done;
   logic            i_rx_done = 1'b0;
   logic [UB-1:0]   i_rx_data = '0;
   logic            o_dump_we;
   logic [DAB-1:0]  o_dump_addr;
   logic [IB-1:0]   o_dump_data;
   logic            o_busy, o_done, o_error;

   debug_host_fsm dut (
      .clk(clk), .rst(rst),
      .i_cmd_load(i_cmd_load), .i_cmd_run(i_cmd_run), .i_cmd_step(i_cmd_step),
      .i_inst_count(i_inst_count), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
      .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_done(i_tx_done),
      .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
      .o_dump_we(o_dump_we), .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int done_cnt = 0, we_cnt = 0, cyc = 0, done_cyc = 0, last_we_cyc = 0;
   logic [UB-1:0] tx_log[$];
   logic [IB-1:0] dump_mem [DW];
   logic [IB-1:0] rom [256];
   logic [3:0]    tx_cnt;
   logic [IB-1:0] rom_q;

   // UART transmitter: goes busy for 5 cycles after each start request
   always @(posedge clk or posedge rst) begin
      if (rst) tx_cnt <= '0;
      else if (o_tx_start) tx_cnt <= 4'd5;
      else if (tx_cnt != 0) tx_cnt <= tx_cnt - 4'd1;
   end
   assign i_tx_done = (tx_cnt == 0);

   always @(posedge clk) rom_q <= rom[o_rom_addr];
   assign i_rom_data = rom_q;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (o_tx_start) tx_log.push_back(o_tx_data);
         if (o_done) begin done_cnt++; done_cyc = cyc; end
         if (o_dump_we) begin
            we_cnt++;
            last_we_cyc = cyc;
            if (o_dump_addr < DAB'(DW)) dump_mem[o_dump_addr] = o_dump_data;
         end
      end
   end

   task automatic clear_logs();
      tx_log.delete();
      done_cnt = 0;
      we_cnt = 0;
      for (int i = 0; i < DW; i++) dump_mem[i] = 'x;
   endtask

   task automatic pulse_cmd(input logic l, input logic r, input logic s, input logic [PCB-1:0] n);
      i_cmd_load = l; i_cmd_run = r; i_cmd_step = s; i_inst_count = n;
      @(negedge clk);
      i_cmd_load = 1'b0; i_cmd_run = 1'b0; i_cmd_step = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int n = 0;
      int start = done_cnt;
      while (done_cnt == start && n < budget) begin
         @(negedge clk);
         n++;
      end
      ok = (done_cnt != start);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({o_tx_start, o_tx_data, o_rom_addr, o_dump_we, o_dump_addr, o_dump_data,
           o_busy, o_done, o_error} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: busy=%b tx_start=%b tx_data=%h rom_addr=%h we=%b required all zero",
                  o_busy, o_tx_start, o_tx_data, o_rom_addr, o_dump_we);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (o_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: busy=%b required 0", o_busy);
      end
   endtask

   task automatic test_load_two();
      logic [UB-1:0] exp[$] = '{8'h01, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      bit ok;
      clear_logs();
      rom[0] = 32'h11223344;
      rom[1] = 32'hAABBCCDD;
      pulse_cmd(1'b1, 1'b0, 1'b0, 8'd2);
      checks++;
      if (o_tx_start !== 1'b1 || o_tx_data !== 8'h01 || o_busy !== 1'b1) begin
         failures++;
         $display("FAIL load2_latency: tx_start=%b tx_data=%h busy=%b required 1/01/1",
                  o_tx_start, o_tx_data, o_busy);
      end
      wait_done(400, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL load2_done_timeout: no o_done within 400 cycles"); end
      checks++;
      if (done_cnt != 1 || tx_log.size() != 10) begin
         failures++;
         $display("FAIL load2_counts: done=%0d tx_starts=%0d required 1/10", done_cnt, tx_log.size());
      end
      for (int i = 0; i < 10 && i < tx_log.size(); i++) begin
         checks++;
         if (tx_log[i] !== exp[i]) begin
            failures++;
            $display("FAIL load2_byte%0d: got %h required %h", i, tx_log[i], exp[i]);
         end
      end
      checks++;
      if (o_rom_addr !== 8'd1 || o_busy !== 1'b0) begin
         failures++;
         $display("FAIL load2_end: rom_addr=%h busy=%b required 01/0", o_rom_addr, o_busy);
      end
   endtask

   task automatic test_load_zero();
      bit ok;
      clear_logs();
      pulse_cmd(1'b1, 1'b0, 1'b0, 8'd0);
      wait_done(200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL load0_done_timeout: no o_done within 200 cycles"); end
      checks++;
      if (tx_log.size() != 2 || done_cnt != 1) begin
         failures++;
         $display("FAIL load0_counts: tx_starts=%0d done=%0d required 2/1", tx_log.size(), done_cnt);
      end else begin
         checks++;
         if (tx_log[0] !== 8'h01 || tx_log[1] !== 8'h00) begin
            failures++;
            $display("FAIL load0_bytes: got %h %h required 01 00", tx_log[0], tx_log[1]);
         end
      end
      checks++;
      if (o_rom_addr !== 8'd0) begin
         failures++;
         $display("FAIL load0_rom_addr: got %h required 00", o_rom_addr);
      end
   endtask

   task automatic test_rx_in_idle();
      clear_logs();
      for (int i = 0; i < 4; i++) begin
         i_rx_done = 1'b1; i_rx_data = 8'hF0 + 8'(i);
         @(negedge clk);
      end
      i_rx_done = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (we_cnt != 0 || o_busy !== 1'b0) begin
         failures++;
         $display("FAIL rx_idle_ignored: writes=%0d busy=%b required 0/0", we_cnt, o_busy);
      end
   endtask

   task automatic test_step_dump();
      bit ok;
      int bad = 0;
      logic [IB-1:0] exp_w;
      clear_logs();
      pulse_cmd(1'b0, 1'b0, 1'b1, 8'd0);
      checks++;
      if (o_tx_start !== 1'b1 || o_tx_data !== 8'h03) begin
         failures++;
         $display("FAIL step_opcode: tx_start=%b tx_data=%h required 1/03", o_tx_start, o_tx_data);
      end
      repeat (15) @(negedge clk);
      for (int i = 0; i < 192; i++) begin
         i_rx_done = 1'b1; i_rx_data = 8'(i);
         @(negedge clk);
      end
      i_rx_done = 1'b0;
      wait_done(50, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL step_done_timeout: no o_done within 50 cycles"); end
      checks++;
      if (we_cnt != 48 || done_cnt != 1 || tx_log.size() != 1) begin
         failures++;
         $display("FAIL step_counts: writes=%0d done=%0d tx=%0d required 48/1/1",
                  we_cnt, done_cnt, tx_log.size());
      end
      checks++;
      if (dump_mem[0] !== 32'h00010203 || dump_mem[47] !== 32'hBCBDBEBF) begin
         failures++;
         $display("FAIL step_edge_words: word0=%h word47=%h required 00010203/BCBDBEBF",
                  dump_mem[0], dump_mem[47]);
      end
      for (int i = 0; i < DW; i++) begin
         exp_w = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
         if (dump_mem[i] !== exp_w) begin
            if (bad < 4) $display("FAIL step_word%0d: got %h required %h", i, dump_mem[i], exp_w);
            bad++;
         end
      end
      checks++;
      if (bad != 0) failures++;
      checks++;
      if (done_cyc - last_we_cyc != 1 || o_busy !== 1'b0) begin
         failures++;
         $display("FAIL step_done_timing: done-lastwrite=%0d busy=%b required 1/0",
                  done_cyc - last_we_cyc, o_busy);
      end
   endtask

   task automatic test_priority();
      logic [UB-1:0] exp[$] = '{8'h01, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      bit ok;
      clear_logs();
      rom[0] = 32'hDEADBEEF;
      pulse_cmd(1'b1, 1'b1, 1'b1, 8'd1);
      checks++;
      if (o_tx_data !== 8'h01) begin
         failures++;
         $display("FAIL prio_first_byte: got %h required 01", o_tx_data);
      end
      repeat (12) @(negedge clk);
      pulse_cmd(1'b0, 1'b1, 1'b0, 8'd0);
      wait_done(300, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL prio_done_timeout: no o_done within 300 cycles"); end
      checks++;
      if (tx_log.size() != 6 || done_cnt != 1 || we_cnt != 0) begin
         failures++;
         $display("FAIL prio_counts: tx=%0d done=%0d writes=%0d required 6/1/0",
                  tx_log.size(), done_cnt, we_cnt);
      end
      for (int i = 0; i < 6 && i < tx_log.size(); i++) begin
         checks++;
         if (tx_log[i] !== exp[i]) begin
            failures++;
            $display("FAIL prio_byte%0d: got %h required %h", i, tx_log[i], exp[i]);
         end
      end
   endtask

   task automatic test_reset_mid_load();
      logic [UB-1:0] exp[$] = '{8'h01, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      bit ok;
      clear_logs();
      rom[0] = 32'h11223344;
      rom[1] = 32'hAABBCCDD;
      pulse_cmd(1'b1, 1'b0, 1'b0, 8'd2);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({o_tx_start, o_tx_data, o_rom_addr, o_dump_we, o_dump_addr, o_dump_data,
           o_busy, o_done, o_error} !== '0) begin
         failures++;
         $display("FAIL midreset_outputs: busy=%b tx_start=%b tx_data=%h required all zero",
                  o_busy, o_tx_start, o_tx_data);
      end
      rst = 1'b0;
      @(negedge clk);
      clear_logs();
      pulse_cmd(1'b1, 1'b0, 1'b0, 8'd2);
      wait_done(400, ok);
      checks++;
      if (!ok || tx_log.size() != 10) begin
         failures++;
         $display("FAIL midreset_reload: done=%0d tx=%0d required 1/10", done_cnt, tx_log.size());
      end
      for (int i = 0; i < 10 && i < tx_log.size(); i++) begin
         checks++;
         if (tx_log[i] !== exp[i]) begin
            failures++;
            $display("FAIL midreset_byte%0d: got %h required %h", i, tx_log[i], exp[i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = '0;
      test_reset();
      test_load_two();
      test_load_zero();
      test_rx_in_idle();
      test_step_dump();
      test_priority();
      test_reset_mid_load();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
